// File: rtl/seven_seg_reader_if.sv
// Decoded-digit stream from seven_seg_reader to its consumer (valid/ready).
// SEVEN_SEG_READER_BLANK_EN adds the out_blank field.
interface seven_seg_reader_if;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_index;
    logic [3:0] out_value;
    logic       out_dp;
    logic       out_err;
`ifdef SEVEN_SEG_READER_BLANK_EN
    logic       out_blank;
`endif

    modport master (
`ifdef SEVEN_SEG_READER_BLANK_EN
        output out_blank,
`endif
        output out_valid, out_index, out_value, out_dp, out_err,
        input  out_ready
    );

    modport slave (
`ifdef SEVEN_SEG_READER_BLANK_EN
        input  out_blank,
`endif
        input  out_valid, out_index, out_value, out_dp, out_err,
        output out_ready
    );
endinterface

// File: rtl/seven_seg_reader.sv
// Reads HEX0..HEX5 back into hex digits, scanning 0..5; SEVEN_SEG_READER_BLANK_EN decodes the all-off glyph as blank.
// Latency: STABLE_CYCLES+2 cycles per digit with constant inputs and out_ready high.
// Backpressure: a presented digit stays frozen until out_ready; input changes meanwhile are ignored.
module seven_seg_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [0:7]  HEX0,
    input  logic [0:7]  HEX1,
    input  logic [0:7]  HEX2,
    input  logic [0:7]  HEX3,
    input  logic [0:7]  HEX4,
    input  logic [0:7]  HEX5,
    seven_seg_reader_if.master out
);

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {CAPTURE, CHECK, PRESENT} state_t;

    state_t     state, state_nxt;
    logic [0:7] hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;
    logic [0:7] sample;
    logic [0:7] ref_pat;
    logic [7:0] cnt;
    logic [2:0] idx;

    logic       ref_load, cnt_clr, cnt_inc, out_load, advance;
    logic [6:0] seg;
    logic [3:0] dec_value;
    logic       dec_err;
    logic       dec_blank;

    // Input register runs through reset so the first capture sees settled data.
    always_ff @(posedge CLOCK_50) begin
        hex0_q <= HEX0;
        hex1_q <= HEX1;
        hex2_q <= HEX2;
        hex3_q <= HEX3;
        hex4_q <= HEX4;
        hex5_q <= HEX5;
    end

    always_comb begin
        case (idx)
            3'd0:    sample = hex0_q;
            3'd1:    sample = hex1_q;
            3'd2:    sample = hex2_q;
            3'd3:    sample = hex3_q;
            3'd4:    sample = hex4_q;
            default: sample = hex5_q;
        endcase
    end

    // Glyph match on g..a only; bit 0 (DP) is reported separately.
    always_comb begin
        seg       = ref_pat[1:7];
        dec_value = 4'h0;
        dec_err   = 1'b0;
        dec_blank = 1'b0;
        case (seg)
            7'h40: dec_value = 4'h0;
            7'h79: dec_value = 4'h1;
            7'h24: dec_value = 4'h2;
            7'h30: dec_value = 4'h3;
            7'h19: dec_value = 4'h4;
            7'h12: dec_value = 4'h5;
            7'h02: dec_value = 4'h6;
            7'h78: dec_value = 4'h7;
            7'h00: dec_value = 4'h8;
            7'h10: dec_value = 4'h9;
            7'h08: dec_value = 4'hA;
            7'h03: dec_value = 4'hB;
            7'h46: dec_value = 4'hC;
            7'h21: dec_value = 4'hD;
            7'h06: dec_value = 4'hE;
            7'h0E: dec_value = 4'hF;
`ifdef SEVEN_SEG_READER_BLANK_EN
            7'h7F: dec_blank = 1'b1;
`endif
            default: dec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ref_load  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        out_load  = 1'b0;
        advance   = 1'b0;
        case (state)
            CAPTURE: begin
                ref_load  = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (sample != ref_pat) begin
                    ref_load = 1'b1;
                    cnt_clr  = 1'b1;
                end else if (cnt == LAST_CNT) begin
                    out_load  = 1'b1;
                    state_nxt = PRESENT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            PRESENT: begin
                if (out.out_ready) begin
                    advance   = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            default: state_nxt = CAPTURE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= CAPTURE;
            idx           <= 3'd0;
            cnt           <= 8'd0;
            ref_pat       <= 8'hFF;
            out.out_valid <= 1'b0;
            out.out_index <= 3'd0;
            out.out_value <= 4'h0;
            out.out_dp    <= 1'b0;
            out.out_err   <= 1'b0;
`ifdef SEVEN_SEG_READER_BLANK_EN
            out.out_blank <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (ref_load) ref_pat <= sample;
            if (cnt_clr)
                cnt <= 8'd0;
            else if (cnt_inc)
                cnt <= cnt + 8'd1;
            if (out_load) begin
                out.out_index <= idx;
                out.out_value <= dec_value;
                out.out_dp    <= ~ref_pat[0];
                out.out_err   <= dec_err;
`ifdef SEVEN_SEG_READER_BLANK_EN
                out.out_blank <= dec_blank;
`endif
            end
            out.out_valid <= (state_nxt == PRESENT);
            if (advance) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

`ifndef SEVEN_SEG_READER_BLANK_EN
    logic unused_blank;
    assign unused_blank = dec_blank;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader: scan order, timing, DP, glitch filtering, backpressure, reset.
module tb_seven_seg_reader;
    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [0:7] hx [6];

    seven_seg_reader_if bus();

    seven_seg_reader #(.STABLE_CYCLES(SC)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .HEX0     (hx[0]),
        .HEX1     (hx[1]),
        .HEX2     (hx[2]),
        .HEX3     (hx[3]),
        .HEX4     (hx[4]),
        .HEX5     (hx[5]),
        .out      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int rel0  = 0;

    typedef struct {
        logic [2:0] index;
        logic [3:0] value;
        logic       dp;
        logic       err;
        logic       blank;
        int         cyc;
    } beat_t;

    beat_t beats [$];

    // Accepted beats, seen mid-cycle before the accepting edge.
    always @(negedge clk) begin
        beat_t b;
        if (!reset && bus.out_valid && bus.out_ready) begin
            b.index = bus.out_index;
            b.value = bus.out_value;
            b.dp    = bus.out_dp;
            b.err   = bus.out_err;
`ifdef SEVEN_SEG_READER_BLANK_EN
            b.blank = bus.out_blank;
`else
            b.blank = 1'b0;
`endif
            b.cyc   = cyc;
            beats.push_back(b);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hex(input logic [7:0] a, b, c, d, e, f);
        hx[0] = a; hx[1] = b; hx[2] = c; hx[3] = d; hx[4] = e; hx[5] = f;
    endtask

    task automatic apply_reset();
        step(1);
        reset = 1'b1;
        step(2);
        beats.delete();
        reset = 1'b0;
        rel0  = cyc;
    endtask

    task automatic wait_beats(input int n, input string tag);
        beat_t dummy;
        int k = 0;
        while (beats.size() < n && k < 400) begin
            step(1);
            k++;
        end
        total++;
        if (beats.size() < n) begin
            bad++;
            $display("FAIL %s_timeout: got %0d beats, need %0d", tag, beats.size(), n);
            dummy = '{index: 3'h7, value: 4'hF, dp: 1'bx, err: 1'bx, blank: 1'bx, cyc: -1000};
            while (beats.size() < n) beats.push_back(dummy);
        end
    endtask

    task automatic test_reset();
        set_hex(8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        step(3);
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_index !== 3'd0) begin bad++; $display("FAIL rst_index: got %0d want 0", bus.out_index); end
        total++; if (bus.out_value !== 4'h0) begin bad++; $display("FAIL rst_value: got %0h want 0", bus.out_value); end
        total++; if (bus.out_dp !== 1'b0) begin bad++; $display("FAIL rst_dp: got %b want 0", bus.out_dp); end
        total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.out_err); end
`ifdef SEVEN_SEG_READER_BLANK_EN
        total++; if (bus.out_blank !== 1'b0) begin bad++; $display("FAIL rst_blank: got %b want 0", bus.out_blank); end
`endif
    endtask

    task automatic test_first_scan();
        logic [3:0] exp_v [6];
        exp_v = '{4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
        set_hex(8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0);
        bus.out_ready = 1'b1;
        apply_reset();
        wait_beats(7, "scan");
        total++;
        if (beats[0].cyc - rel0 !== SC + 1) begin
            bad++; $display("FAIL scan_latency: first valid after edge %0d, want edge %0d", beats[0].cyc - rel0, SC + 1);
        end
        for (int i = 0; i < 6; i++) begin
            total++; if (beats[i].index !== 3'(i)) begin bad++; $display("FAIL scan_index[%0d]: got %0d want %0d", i, beats[i].index, i); end
            total++; if (beats[i].value !== exp_v[i]) begin bad++; $display("FAIL scan_value[%0d]: got %0h want %0h", i, beats[i].value, exp_v[i]); end
            total++; if (beats[i].err !== 1'b0) begin bad++; $display("FAIL scan_err[%0d]: got %b want 0", i, beats[i].err); end
        end
        for (int i = 1; i < 7; i++) begin
            total++;
            if (beats[i].cyc - beats[i-1].cyc !== SC + 2) begin
                bad++; $display("FAIL scan_period[%0d]: got %0d want %0d", i, beats[i].cyc - beats[i-1].cyc, SC + 2);
            end
        end
        total++; if (beats[6].index !== 3'd0) begin bad++; $display("FAIL scan_wrap: got %0d want 0", beats[6].index); end
    endtask

    task automatic test_dp();
        set_hex(8'hF9, 8'hC0, 8'h24, 8'hF9, 8'hC0, 8'hC0);
        bus.out_ready = 1'b1;
        apply_reset();
        wait_beats(3, "dp");
        total++; if (beats[2].index !== 3'd2) begin bad++; $display("FAIL dp_index: got %0d want 2", beats[2].index); end
        total++; if (beats[2].value !== 4'h2) begin bad++; $display("FAIL dp_value: got %0h want 2", beats[2].value); end
        total++; if (beats[2].dp !== 1'b1) begin bad++; $display("FAIL dp_lit: got %b want 1", beats[2].dp); end
        total++; if (beats[2].err !== 1'b0) begin bad++; $display("FAIL dp_err: got %b want 0", beats[2].err); end
        total++; if (beats[0].dp !== 1'b0) begin bad++; $display("FAIL dp_off: got %b want 0", beats[0].dp); end
    endtask

    task automatic test_glitch();
        set_hex(8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0);
        bus.out_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 21; c++) begin
            if (c % 3 == 0) hx[1] = (hx[1] == 8'hC0) ? 8'hF9 : 8'hC0;
            step(1);
        end
        hx[1] = 8'hC0;
        // Final change lands in the input register at edge 22; stable for SC compares after that.
        wait_beats(2, "glitch");
        total++; if (beats[1].index !== 3'd1) begin bad++; $display("FAIL glitch_index: got %0d want 1", beats[1].index); end
        total++; if (beats[1].value !== 4'h0) begin bad++; $display("FAIL glitch_value: got %0h want 0", beats[1].value); end
        total++;
        if (beats[1].cyc - rel0 !== 22 + SC + 1) begin
            bad++; $display("FAIL glitch_time: valid after edge %0d, want %0d", beats[1].cyc - rel0, 22 + SC + 1);
        end
    endtask

    task automatic test_hold();
        int k;
        int held_bad;
        set_hex(8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0);
        bus.out_ready = 1'b1;
        apply_reset();
        step(20);
        bus.out_ready = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 50);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b want 1", bus.out_valid); end
        total++; if (bus.out_index !== 3'd3) begin bad++; $display("FAIL hold_index: got %0d want 3", bus.out_index); end
        total++; if (bus.out_value !== 4'h1) begin bad++; $display("FAIL hold_value: got %0h want 1", bus.out_value); end
        hx[3] = 8'hB0;
        held_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_index !== 3'd3 || bus.out_value !== 4'h1) held_bad++;
        end
        total++; if (held_bad != 0) begin bad++; $display("FAIL hold_frozen: %0d cycles changed, want 0", held_bad); end
        step(1);
        bus.out_ready = 1'b1;
        wait_beats(10, "hold");
        total++; if (beats[3].index !== 3'd3 || beats[3].value !== 4'h1) begin
            bad++; $display("FAIL hold_accept: got idx %0d val %0h want idx 3 val 1", beats[3].index, beats[3].value);
        end
        total++; if (beats[9].index !== 3'd3 || beats[9].value !== 4'h3) begin
            bad++; $display("FAIL hold_rescan: got idx %0d val %0h want idx 3 val 3", beats[9].index, beats[9].value);
        end
    endtask

    task automatic test_blank();
        set_hex(8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hFF, 8'h7F);
        bus.out_ready = 1'b1;
        apply_reset();
        wait_beats(6, "blank");
        total++; if (beats[4].value !== 4'h0) begin bad++; $display("FAIL blank4_value: got %0h want 0", beats[4].value); end
        total++; if (beats[5].value !== 4'h0) begin bad++; $display("FAIL blank5_value: got %0h want 0", beats[5].value); end
        total++; if (beats[5].dp !== 1'b1) begin bad++; $display("FAIL blank5_dp: got %b want 1", beats[5].dp); end
        total++; if (beats[4].dp !== 1'b0) begin bad++; $display("FAIL blank4_dp: got %b want 0", beats[4].dp); end
`ifdef SEVEN_SEG_READER_BLANK_EN
        total++; if (beats[4].err !== 1'b0) begin bad++; $display("FAIL blank4_err: got %b want 0", beats[4].err); end
        total++; if (beats[5].err !== 1'b0) begin bad++; $display("FAIL blank5_err: got %b want 0", beats[5].err); end
        total++; if (beats[4].blank !== 1'b1) begin bad++; $display("FAIL blank4_flag: got %b want 1", beats[4].blank); end
        total++; if (beats[5].blank !== 1'b1) begin bad++; $display("FAIL blank5_flag: got %b want 1", beats[5].blank); end
        total++; if (beats[3].blank !== 1'b0) begin bad++; $display("FAIL blank3_flag: got %b want 0", beats[3].blank); end
`else
        total++; if (beats[4].err !== 1'b1) begin bad++; $display("FAIL blank4_err: got %b want 1", beats[4].err); end
        total++; if (beats[5].err !== 1'b1) begin bad++; $display("FAIL blank5_err: got %b want 1", beats[5].err); end
        total++; if (beats[3].err !== 1'b0) begin bad++; $display("FAIL blank3_err: got %b want 0", beats[3].err); end
`endif
    endtask

    task automatic test_reset_mid();
        int k;
        set_hex(8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0);
        bus.out_ready = 1'b1;
        apply_reset();
        step(14);
        bus.out_ready = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 50);
        total++; if (bus.out_valid !== 1'b1 || bus.out_index !== 3'd2) begin
            bad++; $display("FAIL midrst_pre: got valid %b idx %0d want valid 1 idx 2", bus.out_valid, bus.out_index);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rel0 = cyc;
        beats.delete();
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_drop: got %b want 0", bus.out_valid); end
        bus.out_ready = 1'b1;
        wait_beats(1, "midrst");
        total++; if (beats[0].index !== 3'd0) begin bad++; $display("FAIL midrst_index: got %0d want 0", beats[0].index); end
        total++;
        if (beats[0].cyc - rel0 !== SC + 1) begin
            bad++; $display("FAIL midrst_latency: got %0d want %0d", beats[0].cyc - rel0, SC + 1);
        end
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_dp();
        test_glitch();
        test_hold();
        test_blank();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
